// File: rtl/decode_pkg.sv
// Shared types and helpers for the 3-to-8 decode path.
// Used by the one-hot hold stage and by the 7-seg driver.
package decode_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [ONEHOT_W-1:0] onehot3to8(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dec38_comb.sv
// Pure combinational 3-to-8 decoder with enable.
// Shared with the 7-seg driver.
module dec38_comb
    import decode_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    input  logic                en,
    output logic [ONEHOT_W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = onehot3to8(code);
        end
    end

endmodule

// File: rtl/decode38_hold.sv
// Handshaked 3-to-8 decoder.
// Each accepted code drives a registered one-hot output for HOLD_CYCLES cycles.
module decode38_hold
    import decode_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_flag,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] y,
    output logic                y_active,
    output logic [CNT_W-1:0]    hit_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic [ONEHOT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [ONEHOT_W-1:0] dec_y;
    logic                accept;

    dec38_comb u_dec (
        .code (in_code),
        .en   (in_flag),
        .y    (dec_y)
    );

    assign in_ready = rst_n & ena & (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        y_d     = y_q;
        hit_d   = hit_q;
        if (!ena) begin
            // Disable aborts any pulse in flight but keeps the hit count.
            state_d = IDLE;
            hold_d  = '0;
            y_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && in_flag) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LAST;
                        y_d     = dec_y;
                        hit_d   = hit_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 8'd1;
                    end else begin
                        state_d = IDLE;
                        y_d     = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            y_q     <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            hit_q   <= hit_d;
        end
    end

    assign y        = y_q;
    assign y_active = (state_q == HOLD);
    assign hit_cnt  = hit_q;

endmodule

// File: doc/decode38_hold.md
Name: decode38_hold

Overview:
- Sequential 3-to-8 decoder; the consumer end of the priority-encoder interface (3-bit code plus "input present" flag).
- Accepts one code per handshake and drives a registered one-hot output (LED/segment select) for exactly HOLD_CYCLES cycles.
- Counts accepted non-empty codes, for display/debug.
- Sits between the keypad/switch encoder stage and the board LED/7-seg drivers.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot output stays asserted after acceptance; legal range 1..255
CNT_W, 8, width of hit counter (wraps)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
ena  in  1  block enable; low forces outputs idle
in_valid  in  1  code/flag pair offered this cycle
in_code  in  3  binary code 0..7
in_flag  in  1  1 = code meaningful; 0 = encoder saw no input
in_ready  out  1  block can accept this cycle
y  out  8  registered one-hot output
y_active  out  1  y currently nonzero (state HOLD)
hit_cnt  out  CNT_W  number of accepted codes with in_flag=1, modulo 2^CNT_W

Behaviour:
- Reset, sampled on a rising edge with rst_n=0:
  - state=IDLE, y=8'h00, y_active=0, hold counter=0, hit_cnt=0.
  - in_ready is 0 while rst_n=0.
- in_ready = rst_n & ena & (state==IDLE). It is combinational and does not depend on in_valid.
- Accept = in_valid & in_ready at a rising edge.
- IDLE:
  - Accept with in_flag=1:
    - Next cycle: state=HOLD, y = 1<<in_code, y_active=1, hold counter = HOLD_CYCLES-1.
    - hit_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
  - Accept with in_flag=0: code is ignored, y stays 0, state stays IDLE, hit_cnt unchanged.
  - No accept: hold all state.
- HOLD:
  - in_ready=0, so in_valid is ignored and not accepted.
  - Counter>0: decrement the counter; y is unchanged.
  - Counter==0: next cycle state=IDLE, y=0, y_active=0.
- Latency and throughput:
  - y is first visible the cycle after the accepting edge.
  - y is asserted for exactly HOLD_CYCLES consecutive cycles.
  - The earliest next accept is the first cycle y is back to 0, giving a minimum period of HOLD_CYCLES+1 cycles per code.
- ena=0 at a rising edge, from any state:
  - Next cycle: state=IDLE, y=0, y_active=0, counter=0.
  - hit_cnt holds its value (it is not cleared).
  - No accept is possible, since in_ready=0.
- Reset mid-HOLD: the reset values above apply the next cycle; the stretched pulse is truncated.
- Reset has priority over ena, and ena has priority over the handshake.
- y is always one-hot or zero, never multi-hot. y_active == (y != 0) at all times.
- in_code is 3 bits, so there is no out-of-range case.

Decomposition:
- Shared package (decode_pkg):
  - state enum with IDLE=1'b0 and HOLD=1'b1.
  - localparam CODE_W=3 and ONEHOT_W=8.
  - A function onehot3to8(code) returning 8 bits.
- The pure combinational 3-to-8 decode may be split into a sub-module dec38_comb (inputs code[2:0] and en, output y[7:0]). This sub-module is reused by the 7-seg driver.
- Hold counter, FSM and hit counter stay in decode38_hold.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, ena=1, in_valid=0 -> y=00, y_active=0, hit_cnt=0, in_ready=1.
- Single accept: in_valid=1, in_flag=1, in_code=5 for one cycle with HOLD_CYCLES=4 -> y=0x20 on the next 4 cycles exactly, then 00; hit_cnt=1; in_ready low for those 4 cycles.
- Empty flag: in_valid=1, in_flag=0, in_code=6 -> y stays 00, hit_cnt unchanged, in_ready stays 1.
- Back-to-back offers: in_valid held at 1 with code 0 then code 7 -> y=0x01 for 4 cycles, 1 cycle of 00, then 0x80 for 4 cycles; hit_cnt=2; the code 7 offer is held until in_ready=1.
- Abort: accept code 3, deassert ena in the 2nd HOLD cycle -> y=00 the next cycle; hit_cnt stays 1; no accept while ena=0.
- Reset mid-HOLD and wrap: preload 255 accepts (CNT_W=8) then one more -> hit_cnt=0. Accept code 2, assert rst_n=0 during HOLD -> y=00 the next cycle.
